// File: rtl/cfg_loader_pkg.sv
// Shared constants and helpers for the tile configuration loader.
// Optional parity checking is enabled by defining CFG_LOADER_PARITY_EN.
package cfg_loader_pkg;

  localparam int WR_CNT_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  function automatic int clog2_int(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cfg_loader_if.sv
// Host-side write bus plus element-side write strobes of the configuration loader.
// DATA_PAR exists only when CFG_LOADER_PARITY_EN is defined.
interface cfg_loader_if
  import cfg_loader_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int NB_ELEM = 1,
  parameter int LEN_W   = 4
);
  localparam int IDX_W = max_int(1, clog2_int(NB_ELEM));
  localparam int LOC_W = ADDR_W - IDX_W;

  logic                SELECT;
  logic [ADDR_W-1:0]   ADDRESS;
  logic [DATA_W-1:0]   DATA;
  logic                BURST;
  logic [LEN_W-1:0]    BURST_LEN;
  logic                ERR_CLR;
`ifdef CFG_LOADER_PARITY_EN
  logic                DATA_PAR;
`endif
  logic                READY;
  logic [NB_ELEM-1:0]  SELECT_ELEM;
  logic [LOC_W-1:0]    ADDRESS_ELEM;
  logic [DATA_W-1:0]   DATA_ELEM;
  logic                ERROR;
  logic [WR_CNT_W-1:0] WR_COUNT;

`ifdef CFG_LOADER_PARITY_EN
  modport master (output SELECT, ADDRESS, DATA, BURST, BURST_LEN, ERR_CLR, DATA_PAR,
                  input  READY, SELECT_ELEM, ADDRESS_ELEM, DATA_ELEM, ERROR, WR_COUNT);
  modport slave  (input  SELECT, ADDRESS, DATA, BURST, BURST_LEN, ERR_CLR, DATA_PAR,
                  output READY, SELECT_ELEM, ADDRESS_ELEM, DATA_ELEM, ERROR, WR_COUNT);
`else
  modport master (output SELECT, ADDRESS, DATA, BURST, BURST_LEN, ERR_CLR,
                  input  READY, SELECT_ELEM, ADDRESS_ELEM, DATA_ELEM, ERROR, WR_COUNT);
  modport slave  (input  SELECT, ADDRESS, DATA, BURST, BURST_LEN, ERR_CLR,
                  output READY, SELECT_ELEM, ADDRESS_ELEM, DATA_ELEM, ERROR, WR_COUNT);
`endif

endinterface

// File: rtl/cfg_addr_decode.sv
// Combinational element index to one-hot strobe decoder with an in-range flag.
// Indices at or above NB_ELEM decode to all-zero with in_range low.
module cfg_addr_decode #(
  parameter int NB_ELEM = 1,
  parameter int IDX_W   = 1
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [NB_ELEM-1:0] onehot,
  output logic               in_range
);

  always_comb begin
    in_range = (int'(idx) < NB_ELEM);
    onehot   = '0;
    for (int i = 0; i < NB_ELEM; i++) begin
      onehot[i] = (int'(idx) == i);
    end
  end

endmodule

// File: rtl/cfg_loader_tile.sv
// Tile configuration loader: single writes and address-incrementing bursts to one-hot elements.
// Parity checking on DATA is enabled by defining CFG_LOADER_PARITY_EN.
module cfg_loader_tile
  import cfg_loader_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int NB_ELEM = 1,
  parameter int LEN_W   = 4
) (
  input  logic      CLK,
  input  logic      RESET,
  cfg_loader_if.slave bus
);

  localparam int IDX_W = max_int(1, clog2_int(NB_ELEM));
  localparam int LOC_W = ADDR_W - IDX_W;

  logic [1:0]          state_q, state_d;
  logic                ready_q, ready_d;
  logic [IDX_W-1:0]    elem_q, elem_d;
  logic [LOC_W-1:0]    base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [NB_ELEM-1:0]  sel_q, sel_d;
  logic [LOC_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic [WR_CNT_W-1:0] cnt_q, cnt_d;

  logic               in_burst;
  logic [IDX_W-1:0]   dec_idx;
  logic [LOC_W-1:0]   loc_addr;
  logic [NB_ELEM-1:0] dec_onehot;
  logic               dec_in_range;
  logic               accept;
  logic               par_ok;
  logic               commit;
  logic               err_set;

  // During a burst the element and address come from the latched base, not ADDRESS.
  assign in_burst = (state_q == ST_BURST);
  assign dec_idx  = in_burst ? elem_q : bus.ADDRESS[ADDR_W-1:LOC_W];
  assign loc_addr = in_burst ? base_q + LOC_W'(beat_q) : bus.ADDRESS[LOC_W-1:0];
  assign accept   = ready_q & bus.SELECT;

`ifdef CFG_LOADER_PARITY_EN
  assign par_ok = (bus.DATA_PAR == ^bus.DATA);
`else
  assign par_ok = 1'b1;
`endif

  cfg_addr_decode #(.NB_ELEM(NB_ELEM), .IDX_W(IDX_W)) u_decode (
    .idx      (dec_idx),
    .onehot   (dec_onehot),
    .in_range (dec_in_range)
  );

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    base_d  = base_q;
    len_d   = len_q;
    beat_d  = beat_q;
    sel_d   = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    err_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!dec_in_range || !par_ok) begin
            err_set = 1'b1;
            state_d = ST_HALT;
          end else begin
            commit = 1'b1;
            if (bus.BURST) begin
              elem_d  = dec_idx;
              base_d  = loc_addr;
              len_d   = bus.BURST_LEN;
              beat_d  = LEN_W'(1);
              state_d = (bus.BURST_LEN <= LEN_W'(1)) ? ST_FLUSH : ST_BURST;
            end
          end
        end
      end
      ST_BURST: begin
        if (accept) begin
          if (!par_ok) begin
            err_set = 1'b1;
            state_d = ST_HALT;
          end else begin
            commit = 1'b1;
            if (beat_q == len_q - LEN_W'(1)) state_d = ST_FLUSH;
            else                             beat_d  = beat_q + LEN_W'(1);
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      ST_HALT:  if (bus.ERR_CLR) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (commit) begin
      sel_d  = dec_onehot;
      addr_d = loc_addr;
      data_d = bus.DATA;
      if (cnt_q != '1) cnt_d = cnt_q + WR_CNT_W'(1);
    end

    // A fresh error wins over a simultaneous clear.
    err_d   = err_set | (err_q & ~bus.ERR_CLR);
    ready_d = (state_d == ST_IDLE) || (state_d == ST_BURST);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      elem_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      elem_q  <= elem_d;
      base_q  <= base_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.READY        = ready_q;
  assign bus.SELECT_ELEM  = sel_q;
  assign bus.ADDRESS_ELEM = addr_q;
  assign bus.DATA_ELEM    = data_q;
  assign bus.ERROR        = err_q;
  assign bus.WR_COUNT     = cnt_q;

endmodule

// File: tb/tb_cfg_loader_tile.sv
// Bench for cfg_loader_tile with NB_ELEM=3: directed cases plus random traffic against a beat-countdown model.
// Parity cases are exercised when CFG_LOADER_PARITY_EN is defined.
module tb_cfg_loader_tile;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;
  localparam int NB_ELEM = 3;
  localparam int LEN_W   = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  cfg_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NB_ELEM(NB_ELEM), .LEN_W(LEN_W)) bus ();

  cfg_loader_tile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NB_ELEM(NB_ELEM), .LEN_W(LEN_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining-beat countdown, no state encoding.
  int m_ready, m_sel, m_addr, m_data, m_err, m_cnt;
  int halted, flush, beats_left, next_loc, burst_elem;

  task automatic model_reset();
    m_ready = 0; m_sel = -1; m_addr = 0; m_data = 0; m_err = 0; m_cnt = 0;
    halted = 0; flush = 0; beats_left = 0; next_loc = 0; burst_elem = 0;
  endtask

  task automatic model_step();
    int idx, loc, n;
    bit acc, par_ok, err_set;
    acc     = (m_ready != 0) && bus.SELECT;
    err_set = 0;
`ifdef CFG_LOADER_PARITY_EN
    par_ok = (bus.DATA_PAR == ^bus.DATA);
`else
    par_ok = 1;
`endif
    m_sel = -1;
    flush = 0;
    if (halted != 0) begin
      if (bus.ERR_CLR) halted = 0;
    end else if (acc) begin
      if (beats_left > 0) begin
        if (!par_ok) begin
          err_set = 1; halted = 1; beats_left = 0;
        end else begin
          m_sel = burst_elem; m_addr = next_loc; m_data = int'(bus.DATA);
          next_loc = (next_loc + 1) % 256;
          beats_left--;
          if (beats_left == 0) flush = 1;
        end
      end else begin
        idx = int'(bus.ADDRESS) / 256;
        loc = int'(bus.ADDRESS) % 256;
        if (idx >= NB_ELEM || !par_ok) begin
          err_set = 1; halted = 1;
        end else begin
          m_sel = idx; m_addr = loc; m_data = int'(bus.DATA);
          if (bus.BURST) begin
            n = (bus.BURST_LEN == 0) ? 1 : int'(bus.BURST_LEN);
            beats_left = n - 1; next_loc = (loc + 1) % 256; burst_elem = idx;
            if (beats_left == 0) flush = 1;
          end
        end
      end
    end
    if (m_sel >= 0 && m_cnt < 65535) m_cnt++;
    m_err   = (err_set || (m_err != 0 && !bus.ERR_CLR)) ? 1 : 0;
    m_ready = (halted == 0 && flush == 0) ? 1 : 0;
  endtask

  always @(posedge CLK or posedge RESET) begin
    if (RESET) model_reset();
    else       model_step();
  end

  always @(negedge CLK) begin
    if (check_en) begin
      check("model_ready", 32'(bus.READY), 32'(m_ready));
      check("model_sel", 32'(bus.SELECT_ELEM), (m_sel < 0) ? 32'd0 : (32'd1 << m_sel));
      if (m_sel >= 0) begin
        check("model_addr", 32'(bus.ADDRESS_ELEM), 32'(m_addr));
        check("model_data", 32'(bus.DATA_ELEM), 32'(m_data));
      end
      check("model_err", 32'(bus.ERROR), 32'(m_err));
      check("model_cnt", 32'(bus.WR_COUNT), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [9:0] addr, input logic [7:0] data,
                       input logic burst, input logic [3:0] blen, input logic eclr);
    bus.SELECT    = sel;
    bus.ADDRESS   = addr;
    bus.DATA      = data;
    bus.BURST     = burst;
    bus.BURST_LEN = blen;
    bus.ERR_CLR   = eclr;
`ifdef CFG_LOADER_PARITY_EN
    bus.DATA_PAR  = ^data;
`endif
  endtask

  task automatic pulse_reset();
    #1 RESET = 1'b1;
    #2 RESET = 1'b0;
  endtask

  initial begin
    model_reset();
    drive(0, 10'h000, 8'h00, 0, 4'd0, 0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready", 32'(bus.READY), 32'd0);
    check("rst_sel", 32'(bus.SELECT_ELEM), 32'd0);
    check("rst_addr", 32'(bus.ADDRESS_ELEM), 32'd0);
    check("rst_data", 32'(bus.DATA_ELEM), 32'd0);
    check("rst_err", 32'(bus.ERROR), 32'd0);
    check("rst_cnt", 32'(bus.WR_COUNT), 32'd0);
    RESET = 1'b0;
    check_en = 1'b1;
    tick();
    check("ready_after_reset", 32'(bus.READY), 32'd1);

    // Single write to element 2.
    drive(1, 10'h205, 8'hA5, 0, 4'd0, 0);
    tick();
    check("single_sel", 32'(bus.SELECT_ELEM), 32'b100);
    check("single_addr", 32'(bus.ADDRESS_ELEM), 32'h05);
    check("single_data", 32'(bus.DATA_ELEM), 32'hA5);
    check("single_cnt", 32'(bus.WR_COUNT), 32'd1);
    drive(0, 10'h000, 8'h00, 0, 4'd0, 0);
    tick();
    check("single_one_cycle", 32'(bus.SELECT_ELEM), 32'd0);

    // Four-beat burst on element 1 wrapping the local address, one gap.
    drive(1, 10'h1FE, 8'h10, 1, 4'd4, 0);
    tick();
    check("burst_b0_sel", 32'(bus.SELECT_ELEM), 32'b010);
    check("burst_b0_addr", 32'(bus.ADDRESS_ELEM), 32'hFE);
    drive(1, 10'h3FF, 8'h11, 0, 4'd0, 0);
    tick();
    check("burst_b1_addr", 32'(bus.ADDRESS_ELEM), 32'hFF);
    drive(0, 10'h000, 8'h00, 0, 4'd0, 0);
    tick();
    check("burst_gap_sel", 32'(bus.SELECT_ELEM), 32'd0);
    check("burst_gap_ready", 32'(bus.READY), 32'd1);
    drive(1, 10'h000, 8'h12, 0, 4'd0, 0);
    tick();
    check("burst_b2_addr", 32'(bus.ADDRESS_ELEM), 32'h00);
    drive(1, 10'h000, 8'h13, 0, 4'd0, 0);
    tick();
    check("burst_b3_addr", 32'(bus.ADDRESS_ELEM), 32'h01);
    check("burst_b3_sel", 32'(bus.SELECT_ELEM), 32'b010);
    check("flush_ready", 32'(bus.READY), 32'd0);
    drive(1, 10'h005, 8'h14, 0, 4'd0, 0);
    tick();
    check("flush_drop", 32'(bus.SELECT_ELEM), 32'd0);
    check("flush_done_ready", 32'(bus.READY), 32'd1);
    check("burst_cnt", 32'(bus.WR_COUNT), 32'd5);

    // Out-of-range index halts until cleared.
    drive(1, 10'h305, 8'h77, 0, 4'd0, 0);
    tick();
    check("oor_sel", 32'(bus.SELECT_ELEM), 32'd0);
    check("oor_err", 32'(bus.ERROR), 32'd1);
    check("oor_ready", 32'(bus.READY), 32'd0);
    drive(1, 10'h001, 8'h01, 0, 4'd0, 0);
    repeat (3) tick();
    check("halt_ready", 32'(bus.READY), 32'd0);
    check("halt_cnt", 32'(bus.WR_COUNT), 32'd5);
    drive(0, 10'h000, 8'h00, 0, 4'd0, 1);
    tick();
    check("clr_err", 32'(bus.ERROR), 32'd0);
    check("clr_ready", 32'(bus.READY), 32'd1);

    // New error and clear together keep ERROR set.
    drive(1, 10'h3AA, 8'h00, 0, 4'd0, 1);
    tick();
    check("err_and_clr", 32'(bus.ERROR), 32'd1);
    drive(0, 10'h000, 8'h00, 0, 4'd0, 1);
    tick();
    check("err_and_clr_recover", 32'(bus.READY), 32'd1);
    drive(0, 10'h000, 8'h00, 0, 4'd0, 0);
    tick();

    // Reset in the middle of an eight-beat burst.
    drive(1, 10'h010, 8'h20, 1, 4'd8, 0);
    tick();
    drive(1, 10'h000, 8'h21, 0, 4'd0, 0);
    tick();
    drive(1, 10'h000, 8'h22, 0, 4'd0, 0);
    tick();
    check("pre_rst_addr", 32'(bus.ADDRESS_ELEM), 32'h12);
    #1 RESET = 1'b1;
    #1;
    check("midrst_sel", 32'(bus.SELECT_ELEM), 32'd0);
    check("midrst_addr", 32'(bus.ADDRESS_ELEM), 32'd0);
    check("midrst_data", 32'(bus.DATA_ELEM), 32'd0);
    check("midrst_cnt", 32'(bus.WR_COUNT), 32'd0);
    drive(0, 10'h000, 8'h00, 0, 4'd0, 0);
    RESET = 1'b0;
    repeat (4) begin
      tick();
      check("postrst_sel", 32'(bus.SELECT_ELEM), 32'd0);
    end
    check("postrst_cnt", 32'(bus.WR_COUNT), 32'd0);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            10'($urandom_range(0, 1023)), 8'($urandom),
            ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
`ifdef CFG_LOADER_PARITY_EN
      bus.DATA_PAR = (^bus.DATA) ^ ($urandom_range(0, 19) == 0);
`endif
      tick();
      if ($urandom_range(0, 399) == 0) pulse_reset();
    end

`ifdef CFG_LOADER_PARITY_EN
    pulse_reset();
    tick();
    drive(1, 10'h005, 8'h03, 0, 4'd0, 0);
    bus.DATA_PAR = 1'b1;
    tick();
    check("par_sel", 32'(bus.SELECT_ELEM), 32'd0);
    check("par_err", 32'(bus.ERROR), 32'd1);
    check("par_ready", 32'(bus.READY), 32'd0);
`endif

    // Drive the write counter into saturation.
    pulse_reset();
    tick();
    drive(1, 10'h100, 8'h5A, 0, 4'd0, 0);
    repeat (65535) tick();
    check("sat_reach", 32'(bus.WR_COUNT), 32'hFFFF);
    repeat (4) tick();
    check("sat_hold", 32'(bus.WR_COUNT), 32'hFFFF);
    check("sat_still_strobes", 32'(bus.SELECT_ELEM), 32'b010);
    drive(0, 10'h000, 8'h00, 0, 4'd0, 0);
    tick();
    @(negedge CLK);
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
